writeback_unit: RTL and testbench

Writeback stage feeding the decode-stage register-file write port. Accepts results from the ALU and memory stages over valid/ready handshakes, buffers them in an in-order FIFO, and drives one scalar or vector register write per cycle. The registered write outputs are captured by the register files on the falling clock edge, so decode reads the written value in the same cycle.

---
 rtl/writeback_unit_if.sv | 47 ++++
 rtl/writeback_unit.sv | 126 ++++++++++++
 tb/tb_writeback_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Handshake and write-port bundle for writeback_unit: mem/alu result sources plus register-file write outputs.
interface writeback_unit_if #(
  parameter int SCALAR_DATA_WIDTH = 48,
  parameter int VECTOR_DATA_WIDTH = 8,
  parameter int VECTOR_SIZE       = 6,
  parameter int ADDRESS_WIDTH     = 4,
  parameter int DEPTH             = 4
);
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

  logic                                            memValid;
  logic                                            memReady;
  logic                                            memIsVector;
  logic [ADDRESS_WIDTH-1:0]                        memAddress;
  logic [SCALAR_DATA_WIDTH-1:0]                    memScalarData;
  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   memVectorData;

  logic                                            aluValid;
  logic                                            aluReady;
  logic                                            aluIsVector;
  logic [ADDRESS_WIDTH-1:0]                        aluAddress;
  logic [SCALAR_DATA_WIDTH-1:0]                    aluScalarData;
  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   aluVectorData;

  logic                                            writeEnableScalar;
  logic                                            writeEnableVector;
  logic [ADDRESS_WIDTH-1:0]                        writeAddress;
  logic [SCALAR_DATA_WIDTH-1:0]                    writeScalarData;
  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   writeVectorData;
  logic [COUNT_WIDTH-1:0]                          pendingCount;

  modport master (
    output memValid, memIsVector, memAddress, memScalarData, memVectorData,
    output aluValid, aluIsVector, aluAddress, aluScalarData, aluVectorData,
    input  memReady, aluReady,
    input  writeEnableScalar, writeEnableVector, writeAddress, writeScalarData, writeVectorData,
    input  pendingCount
  );

  modport slave (
    input  memValid, memIsVector, memAddress, memScalarData, memVectorData,
    input  aluValid, aluIsVector, aluAddress, aluScalarData, aluVectorData,
    output memReady, aluReady,
    output writeEnableScalar, writeEnableVector, writeAddress, writeScalarData, writeVectorData,
    output pendingCount
  );
endinterface

// File: rtl/writeback_unit.sv
// In-order writeback FIFO merging mem and alu results into one register write per cycle.
// Define WB_BYPASS_EN to let the oldest accepted result skip an empty FIFO straight into the write registers.
module writeback_unit #(
  parameter int SCALAR_DATA_WIDTH = 48,
  parameter int VECTOR_DATA_WIDTH = 8,
  parameter int VECTOR_SIZE       = 6,
  parameter int ADDRESS_WIDTH     = 4,
  parameter int DEPTH             = 4
) (
  input logic            clock,
  input logic            reset,
  writeback_unit_if.slave bus
);
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH   = $clog2(DEPTH);

  typedef logic [COUNT_WIDTH-1:0] count_t;
  typedef logic [PTR_WIDTH-1:0]   ptr_t;
  typedef struct packed {
    logic                                          isVector;
    logic [ADDRESS_WIDTH-1:0]                      address;
    logic [SCALAR_DATA_WIDTH-1:0]                  scalarData;
    logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] vectorData;
  } entry_t;

  entry_t storage [DEPTH];
  ptr_t   headPtr;
  ptr_t   tailPtr;
  count_t pendingCount;
  count_t freeCount;
  count_t pushCount;
  entry_t memEntry;
  entry_t aluEntry;
  entry_t slot0Entry;
  entry_t outEntry;
  logic   memReady;
  logic   aluReady;
  logic   memPush;
  logic   aluPush;
  logic   pop;
  logic   slot0Write;
  logic   slot1Write;
  logic   writeEnableScalar;
  logic   writeEnableVector;
`ifdef WB_BYPASS_EN
  logic   bypassLoad;
  entry_t bypassEntry;
`endif

  // Readiness uses registered occupancy only, so a same-cycle pop never frees a slot early.
  assign freeCount = count_t'(DEPTH) - pendingCount;
  assign memReady  = freeCount >= count_t'(1);
  assign aluReady  = (freeCount >= count_t'(2)) || ((freeCount >= count_t'(1)) && !bus.memValid);
  assign memPush   = bus.memValid && memReady;
  assign aluPush   = bus.aluValid && aluReady;
  assign pop       = pendingCount != '0;

  assign memEntry = {bus.memIsVector, bus.memAddress, bus.memScalarData, bus.memVectorData};
  assign aluEntry = {bus.aluIsVector, bus.aluAddress, bus.aluScalarData, bus.aluVectorData};

  // Mem is the older instruction, so it always takes the first slot when both arrive together.
  always_comb begin
    slot0Entry = memPush ? memEntry : aluEntry;
    slot0Write = memPush || aluPush;
    slot1Write = memPush && aluPush;
`ifdef WB_BYPASS_EN
    bypassLoad  = 1'b0;
    bypassEntry = slot0Entry;
    if (!pop && (memPush || aluPush)) begin
      bypassLoad = 1'b1;
      slot0Entry = aluEntry;
      slot0Write = memPush && aluPush;
      slot1Write = 1'b0;
    end
`endif
    pushCount = count_t'(slot0Write) + count_t'(slot1Write);
  end

  always_ff @(posedge clock) begin
    if (slot0Write) storage[tailPtr] <= slot0Entry;
    if (slot1Write) storage[tailPtr + ptr_t'(1)] <= aluEntry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      headPtr      <= '0;
      tailPtr      <= '0;
      pendingCount <= '0;
    end else begin
      headPtr      <= headPtr + ptr_t'(pop);
      tailPtr      <= tailPtr + ptr_t'(pushCount);
      pendingCount <= pendingCount + pushCount - count_t'(pop);
    end
  end

  // Address and data hold their last value when idle; only the enables drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outEntry          <= '0;
      writeEnableScalar <= 1'b0;
      writeEnableVector <= 1'b0;
    end else if (pop) begin
      outEntry          <= storage[headPtr];
      writeEnableScalar <= !storage[headPtr].isVector;
      writeEnableVector <= storage[headPtr].isVector;
`ifdef WB_BYPASS_EN
    end else if (bypassLoad) begin
      outEntry          <= bypassEntry;
      writeEnableScalar <= !bypassEntry.isVector;
      writeEnableVector <= bypassEntry.isVector;
`endif
    end else begin
      writeEnableScalar <= 1'b0;
      writeEnableVector <= 1'b0;
    end
  end

  assign bus.memReady          = memReady;
  assign bus.aluReady          = aluReady;
  assign bus.writeEnableScalar = writeEnableScalar;
  assign bus.writeEnableVector = writeEnableVector;
  assign bus.writeAddress      = outEntry.address;
  assign bus.writeScalarData   = outEntry.scalarData;
  assign bus.writeVectorData   = outEntry.vectorData;
  assign bus.pendingCount      = pendingCount;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: accepted results are queued in acceptance order and matched against register writes.
module tb_writeback_unit;
  localparam int SW    = 48;
  localparam int VW    = 8;
  localparam int VS    = 6;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  typedef logic [VS-1:0][VW-1:0] vec_t;
  typedef struct packed {
    logic          isVector;
    logic [AW-1:0] address;
    logic [SW-1:0] scalarData;
    vec_t          vectorData;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  writeback_unit_if #(
    .SCALAR_DATA_WIDTH(SW), .VECTOR_DATA_WIDTH(VW), .VECTOR_SIZE(VS),
    .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)
  ) bus ();

  writeback_unit #(
    .SCALAR_DATA_WIDTH(SW), .VECTOR_DATA_WIDTH(VW), .VECTOR_SIZE(VS),
    .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     failures = 0;
  entry_t sbq[$];
  int     modelCount = 0;
  bit     expWrite = 1'b0;
  entry_t expEntry = '0;
  entry_t lastOut = '0;
  bit     memAcc = 1'b0;
  bit     aluAcc = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic entry_t mkEntry(input bit isVec, input logic [AW-1:0] addr,
                                     input logic [SW-1:0] s, input logic [VW-1:0] base);
    entry_t e;
    e.isVector   = isVec;
    e.address    = addr;
    e.scalarData = s;
    for (int i = 0; i < VS; i++) e.vectorData[i] = base + VW'(i);
    return e;
  endfunction

  function automatic entry_t randEntry();
    return mkEntry(1'($urandom_range(0, 1)), AW'($urandom), SW'({$urandom, $urandom}), VW'($urandom));
  endfunction

  // Drive one cycle of source stimulus; returns 2 time units after the sampling edge.
  task automatic applyStimulus(input bit mv, input entry_t me, input bit av, input entry_t ae);
    bus.memValid      = mv;
    bus.memIsVector   = me.isVector;
    bus.memAddress    = me.address;
    bus.memScalarData = me.scalarData;
    bus.memVectorData = me.vectorData;
    bus.aluValid      = av;
    bus.aluIsVector   = ae.isVector;
    bus.aluAddress    = ae.address;
    bus.aluScalarData = ae.scalarData;
    bus.aluVectorData = ae.vectorData;
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: check outputs of the last edge, then predict the coming edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        checkOutput("rstEnScalar", 64'(bus.writeEnableScalar), 64'd0);
        checkOutput("rstEnVector", 64'(bus.writeEnableVector), 64'd0);
        checkOutput("rstCount", 64'(bus.pendingCount), 64'd0);
        sbq.delete();
        modelCount = 0;
        expWrite   = 1'b0;
        lastOut    = '0;
        memAcc     = 1'b0;
        aluAcc     = 1'b0;
      end else begin
        int     freeSlots;
        int     pushes;
        bit     expMemReady;
        bit     expAluReady;
        bit     doPop;
        if (expWrite) lastOut = expEntry;
        checkOutput("enScalar", 64'(bus.writeEnableScalar), 64'(expWrite && !expEntry.isVector));
        checkOutput("enVector", 64'(bus.writeEnableVector), 64'(expWrite && expEntry.isVector));
        checkOutput("writeAddress", 64'(bus.writeAddress), 64'(lastOut.address));
        checkOutput("writeScalar", 64'(bus.writeScalarData), 64'(lastOut.scalarData));
        checkOutput("writeVector", 64'(bus.writeVectorData), 64'(lastOut.vectorData));
        checkOutput("pendingCount", 64'(bus.pendingCount), 64'(modelCount));

        freeSlots   = DEPTH - modelCount;
        expMemReady = freeSlots >= 1;
        expAluReady = (freeSlots >= 2) || ((freeSlots >= 1) && !bus.memValid);
        checkOutput("memReady", 64'(bus.memReady), 64'(expMemReady));
        checkOutput("aluReady", 64'(bus.aluReady), 64'(expAluReady));
        memAcc = bus.memValid && expMemReady;
        aluAcc = bus.aluValid && expAluReady;

        doPop = modelCount > 0;
        if (doPop) expEntry = sbq.pop_front();
        if (memAcc) sbq.push_back({bus.memIsVector, bus.memAddress, bus.memScalarData, bus.memVectorData});
        if (aluAcc) sbq.push_back({bus.aluIsVector, bus.aluAddress, bus.aluScalarData, bus.aluVectorData});
        pushes   = int'(memAcc) + int'(aluAcc);
        expWrite = doPop;
`ifdef WB_BYPASS_EN
        if (!doPop && pushes > 0) begin
          expEntry = sbq.pop_front();
          expWrite = 1'b1;
          pushes--;
        end
`endif
        modelCount = modelCount + pushes - int'(doPop);
      end
    end
  end

  initial begin
    entry_t mCur;
    entry_t aCur;
    bit     mV;
    bit     aV;
    int     mSeq;
    int     aSeq;

    bus.memValid = 1'b0;
    bus.aluValid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Single scalar alu write.
    applyStimulus(1'b0, '0, 1'b1, mkEntry(1'b0, 4'd3, 48'h1234, 8'h00));
    idle(4);
    checkOutput("singleDrained", 64'(bus.pendingCount), 64'd0);

    // Same-cycle mem vector and alu scalar; mem must be written first.
    applyStimulus(1'b1, mkEntry(1'b1, 4'd5, 48'hAAAA, 8'h01), 1'b1, mkEntry(1'b0, 4'd7, 48'h7777, 8'h00));
    idle(4);

    // Two rounds of sustained dual-source traffic; the second round wraps the pointers.
    for (int round = 0; round < 2; round++) begin
      mSeq = 0;
      aSeq = 0;
      for (int c = 0; c < 10; c++) begin
        applyStimulus(1'b1, mkEntry(1'b1, AW'(mSeq), SW'(48'h100 + mSeq), VW'(8'h10 * mSeq)),
                      1'b1, mkEntry(1'b0, AW'(8 + aSeq), SW'(48'h200 + aSeq), VW'(8'h80 + aSeq)));
        if (memAcc) mSeq++;
        if (aluAcc) aSeq++;
      end
      idle(6);
      checkOutput("burstDrained", 64'(bus.pendingCount), 64'd0);
    end

    // Random traffic; a rejected source holds its payload until accepted.
    mV   = 1'b0;
    aV   = 1'b0;
    mCur = randEntry();
    aCur = randEntry();
    for (int c = 0; c < 60; c++) begin
      applyStimulus(mV, mCur, aV, aCur);
      if (!mV || memAcc) begin
        mV   = 1'($urandom_range(0, 1));
        mCur = randEntry();
      end
      if (!aV || aluAcc) begin
        aV   = 1'($urandom_range(0, 1));
        aCur = randEntry();
      end
    end
    idle(6);

    // Queue entries, then flush them with an asynchronous reset.
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b1, mkEntry(1'b0, AW'(c), SW'(48'hDEAD00 + c), 8'h33),
                    1'b1, mkEntry(1'b1, AW'(c + 4), SW'(48'hBEEF00 + c), 8'h44));
    bus.memValid = 1'b0;
    bus.aluValid = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("asyncEnScalar", 64'(bus.writeEnableScalar), 64'd0);
    checkOutput("asyncEnVector", 64'(bus.writeEnableVector), 64'd0);
    checkOutput("asyncAddress", 64'(bus.writeAddress), 64'd0);
    checkOutput("asyncScalar", 64'(bus.writeScalarData), 64'd0);
    checkOutput("asyncVector", 64'(bus.writeVectorData), 64'd0);
    checkOutput("asyncCount", 64'(bus.pendingCount), 64'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    idle(5);
    applyStimulus(1'b0, '0, 1'b1, mkEntry(1'b0, 4'd9, 48'h55AA, 8'h00));
    idle(4);
    checkOutput("scoreboardEmpty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
